// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bundle between the EX-stage decoder and muldiv_ctrl.
// master: the EX stage (drives start, flags and operands, sees stall/results).
// slave : the mult/div sequencer.
interface muldiv_ctrl_if;
    logic        start;
    logic        ismult;
    logic        signedmult;
    logic        isdiv;
    logic        signeddiv;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, ismult, signedmult, isdiv, signeddiv, a, b, cancel,
        input  stall, busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, ismult, signedmult, isdiv, signeddiv, a, b, cancel,
        output stall, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the HI/LO unit.
// 2-cycle multiply, 32-iteration restoring divide on operand magnitudes with
// a sign fix-up applied as the result is loaded into hi_out/lo_out.
// Optional build macro MULDIV_DIVZERO_FAST_EN: a divide by zero skips the
// iterations and returns hi_out = a (raw), lo_out = all ones.
//
// state | meaning
// IDLE  | waiting for a mult/div instruction
// MUL   | product computed and loaded into hi/lo
// DIV   | one restoring divide step per cycle, counter 0..31
// DONE  | done pulses, results valid; back to IDLE
module muldiv_ctrl (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        smul_q, smul_d;
    logic        sdiv_q, sdiv_d;
    logic        nega_q, nega_d;
    logic        negq_q, negq_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted, diff;
    logic [31:0] step_rem, step_quo;

    // Operand extension and a 64-bit product; the low 64 bits of a
    // sign-extended multiply equal the signed 32x32 product.
    assign a_ext = smul_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext = smul_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = a_ext * b_ext;

    // Magnitudes for a signed divide; -2^31 wraps to itself, which still
    // reads correctly as an unsigned magnitude.
    assign mag_a = (bus.signeddiv && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign mag_b = (bus.signeddiv && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    // One restoring step: shift {rem, quo} left and trial-subtract. The
    // remainder stays below the divisor, so 33 bits hold the shifted value.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, b_q};
    assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    assign step_quo = {quo_q[30:0], ~diff[32]};

    // Next-state and datapath decode; cancel takes priority in every state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        smul_d  = smul_q;
        sdiv_d  = sdiv_q;
        nega_d  = nega_q;
        negq_d  = negq_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (bus.cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && bus.ismult) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        smul_d  = bus.signedmult;
                        state_d = MUL;
                    end else if (bus.start && bus.isdiv) begin
                        quo_d   = mag_a;
                        b_d     = mag_b;
                        rem_d   = 32'd0;
                        nega_d  = bus.a[31];
                        negq_d  = bus.a[31] ^ bus.b[31];
                        sdiv_d  = bus.signeddiv;
                        cnt_d   = 6'd0;
                        state_d = DIV;
`ifdef MULDIV_DIVZERO_FAST_EN
                        if (bus.b == 32'd0) begin
                            hi_d    = bus.a;
                            lo_d    = 32'hFFFF_FFFF;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
`endif
                    end
                end
                MUL: begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                DIV: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        hi_d    = (sdiv_q && nega_q) ? (32'd0 - step_rem) : step_rem;
                        lo_d    = (sdiv_q && negq_q) ? (32'd0 - step_quo) : step_quo;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            smul_q  <= 1'b0;
            sdiv_q  <= 1'b0;
            nega_q  <= 1'b0;
            negq_q  <= 1'b0;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            smul_q  <= smul_d;
            sdiv_q  <= sdiv_d;
            nega_q  <= nega_d;
            negq_q  <= negq_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall covers the issue cycle so the instruction holds in EX until DONE.
    assign bus.stall  = (bus.start && (bus.ismult || bus.isdiv) && (state_q == IDLE) && !bus.cancel)
                        || (state_q == MUL) || (state_q == DIV);
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.ismult     = 1'b0;
        bus.signedmult = 1'b0;
        bus.isdiv      = 1'b0;
        bus.signeddiv  = 1'b0;
    endtask

    // Issues one operation at the next falling edge (cycle 0) and watches
    // 36 cycles: stall profile, single done pulse at exp_cyc, final hi/lo.
    // poke re-asserts start with mult flags in cycles 3..5 (must be ignored).
    task automatic run_op(input string nm, input logic im, input logic sm,
                          input logic id, input logic sd,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int exp_cyc, input logic [31:0] eh,
                          input logic [31:0] el, input bit poke);
        int done_cyc;
        int done_cnt;
        int stall_bad;
        @(negedge clk);
        bus.start = 1'b1; bus.ismult = im; bus.signedmult = sm;
        bus.isdiv = id; bus.signeddiv = sd; bus.a = av; bus.b = bv;
        #1;
        checks++;
        if (bus.stall !== 1'b1)
            $display("FAIL %s stall_c0: got %b want 1", nm, bus.stall);
        if (bus.stall !== 1'b1) errors++;
        done_cyc = -1; done_cnt = 0; stall_bad = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            clear_inputs();
            if (poke && c >= 3 && c <= 5) begin
                bus.start = 1'b1; bus.ismult = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
            end
            #1;
            if (bus.done === 1'b1) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            if (bus.stall !== logic'(c < exp_cyc)) stall_bad++;
        end
        clear_inputs();
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall_profile: %0d bad cycles, want 0", nm, stall_bad);
        end
        checks++;
        if (done_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", nm, done_cyc, exp_cyc);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", nm, done_cnt);
        end
        checks++;
        if (bus.hi_out !== eh) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", nm, bus.hi_out, eh);
        end
        checks++;
        if (bus.lo_out !== el) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", nm, bus.lo_out, el);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.cancel = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
        checks++;
        if (bus.hi_out !== 32'd0) begin errors++; $display("FAIL reset hi: got %h want 0", bus.hi_out); end
        checks++;
        if (bus.lo_out !== 32'd0) begin errors++; $display("FAIL reset lo: got %h want 0", bus.lo_out); end
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b want 0", bus.stall); end
        rst = 1'b0;
    endtask

    task automatic test_mult();
        run_op("mult_neg2x3", 1, 1, 0, 0, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("multu_neg2x3", 1, 0, 0, 0, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA, 0);
    endtask

    task automatic test_div();
        run_op("divu_100_7", 0, 0, 1, 0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0);
        run_op("div_m7_2", 0, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ovf", 0, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 0);
        run_op("divu_busy_start", 0, 0, 1, 0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1);
    endtask

    task automatic test_divzero();
`ifdef MULDIV_DIVZERO_FAST_EN
        run_op("div_5_0", 0, 0, 1, 1, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 0);
`else
        run_op("div_5_0", 0, 0, 1, 1, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 0);
`endif
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd3;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL noflag stall: got %b want 0", bus.stall); end
        @(negedge clk);
        bus.ismult = 1'b1; bus.cancel = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL noflag busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL cancel_start stall: got %b want 0", bus.stall); end
        @(negedge clk);
        clear_inputs();
        bus.cancel = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_start busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_cancel();
        int done_cnt;
        run_op("cancel_pre_multu", 1, 0, 0, 0, 32'd7, 32'd6, 2, 32'd0, 32'd42, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.isdiv = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
        done_cnt = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.cancel = (c == 10);
            #1;
            if (bus.done === 1'b1) done_cnt++;
            if (c == 9) begin
                checks++;
                if (bus.busy !== 1'b1) begin errors++; $display("FAIL cancel busy_c9: got %b want 1", bus.busy); end
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel busy_c11: got %b want 0", bus.busy); end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL cancel done: got %0d pulses want 0", done_cnt); end
        checks++;
        if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd42) begin
            errors++;
            $display("FAIL cancel hold: got %h/%h want 00000000/0000002a", bus.hi_out, bus.lo_out);
        end
        run_op("mult_after_cancel", 1, 1, 0, 0, 32'hFFFF_FFFF, 32'h10, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.isdiv = 1'b1; bus.a = 32'd50; bus.b = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            clear_inputs();
        end
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL arst busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL arst ctrl: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            errors++;
            $display("FAIL arst data: got %h/%h want 0/0", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL arst stall: got %b want 0", bus.stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_ignored_start();
        test_cancel();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the HI/LO unit. When the EX stage decodes MULT/MULTU/DIV/DIVU, this block captures the operands, runs a 2-cycle multiply or a 32-iteration restoring divide, and holds the pipeline stalled until the result is ready. On completion it presents the 64-bit result for HI/LO writeback. It sits beside the ALU in EX and is driven by the decoder's `ismult`, `signedmult`, `isdiv` and `signeddiv` flags.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  EX stage holds a mult/div instruction (decoder flags valid)
- `ismult`, `signedmult`, `isdiv`, `signeddiv`  in  1 each  decoder flags, sampled with `start`
- `a`  in  32  rs value (multiplicand or dividend)
- `b`  in  32  rt value (multiplier or divisor)
- `cancel`  in  1  flush (exception or redirect); aborts the current operation
- `stall`  out  1  freeze IF/ID/EX while an operation is pending
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle pulse; `hi_out`/`lo_out` valid and should be written to HI/LO
- `hi_out`  out  32  product[63:32], or remainder
- `lo_out`  out  32  product[31:0], or quotient

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: on `start & ismult`, latch `a`, `b` and `signedmult`, then go to MUL. On `start & isdiv & ~ismult`, latch the operand magnitudes, sign of `a`, sign of `a`^`b` and `signeddiv`, clear the iteration counter, then go to DIV. `start` with neither flag set is ignored.
- MUL: register the 64-bit product (signed if `signedmult`, else unsigned), then go to DONE.
- DIV: one restoring step per cycle on the 32-bit magnitudes. Shift the {rem, quo} pair left, trial-subtract the divisor, and set the quotient bit if the result is non-negative. The 6-bit counter counts 0..31; after iteration 31, go to DONE.
- DONE: for signed divide, negate the quotient if the latched sign of `a`^`b` is set, and negate the remainder if the sign of `a` is set. Unsigned results pass through unchanged. Load `hi_out`/`lo_out`, pulse `done`, then return to IDLE.
- `cancel` is checked first in every state. The next state is IDLE, no `done` is raised, and `hi_out`/`lo_out` are unchanged. `cancel` also wins over a simultaneous `start`.
- `start` while `busy` is ignored. The pipeline is stalled, so the same instruction cannot re-issue.
- Signed overflow case: -2^31 / -1 gives quotient 0x80000000 and remainder 0. Results wrap; no trap is raised.
- `hi_out`/`lo_out` hold their last value until the next DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, counter 0, all operand registers 0.
- `stall` is combinational: `(start & (ismult|isdiv) & state==IDLE & ~cancel) | state==MUL | state==DIV`.
- `stall` is low in DONE, so the held instruction advances in the same cycle that `done` pulses.
- Multiply latency: `start` is sampled at edge 0; MUL occupies cycle 1; DONE and `done` occur in cycle 2. `stall` is high for cycles 0–1.
- Divide latency: `start` is sampled at edge 0; DIV occupies cycles 1–32; DONE occurs in cycle 33. `stall` is high for cycles 0–32.
- `done`, `hi_out` and `lo_out` are registered outputs, updated on the edge that enters DONE.
- An asynchronous `rst` during MUL or DIV forces IDLE immediately and clears all outputs.

## Configuration
- `MULDIV_DIVZERO_FAST_EN` defined:
  - A divide with `b`==0 goes from IDLE directly to DONE with no iterations.
  - Result: `hi_out`=`a` (raw) and `lo_out`=32'hFFFFFFFF, with no sign fix-up.
  - `done` pulses at cycle 1 and `stall` is high only in cycle 0.
- `MULDIV_DIVZERO_FAST_EN` undefined:
  - Divide by zero runs all 32 iterations and is sign-fixed like any divide.
  - Result: raw quotient 32'hFFFFFFFF, raw remainder = |`a`|.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> `done` at cycle 2; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU a=100, b=7 -> `stall` high for cycles 0–32; `done` at cycle 33; lo=14, hi=2.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIV a=5, b=0:
  - macro defined -> `done` at cycle 1, hi=5, lo=0xFFFFFFFF.
  - macro undefined -> `done` at cycle 33, lo=0xFFFFFFFF, hi=5.
- DIVU started, `cancel` pulsed at cycle 10 -> IDLE at cycle 11, no `done`, hi/lo keep the previous values. A new MULT issued at cycle 12 completes normally at cycle 14.
- Assert `rst` asynchronously mid-divide (cycle 20) -> `busy`, `done`, `hi_out`, `lo_out` = 0 immediately; `stall` low with `start`=0.
